scrbrd_alloc: RTL and testbench
===============================

Name: scrbrd_alloc

Overview:
- In-order allocator that sits directly upstream of the scoreboard and is its only writer.
- Accepts dispatched instructions (PC, opcode) and assigns each a scoreboard index in circular order.
- Accepts completion events by index, retires completed entries in program order, and supports a multi-cycle flush.
- Emits at most one registered scoreboard command per cycle, so all command fields share one index bus.

Parameters:
SCRBRD_SIZE, 32, number of scoreboard entries; power of two, >=2; IDX_W = $clog2(SCRBRD_SIZE)
PC_WIDTH, 32, PC width
OPCODE_WIDTH, 7, opcode width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low
disp_vld  in  1  dispatch request
disp_rdy  out  1  dispatch accepted when disp_vld&&disp_rdy
disp_pc  in  PC_WIDTH  dispatched PC
disp_opcode  in  OPCODE_WIDTH  dispatched opcode
disp_idx  out  IDX_W  index assigned; valid in the handshake cycle (equals tail)
cpl_vld  in  1  completion request
cpl_rdy  out  1  completion accepted when cpl_vld&&cpl_rdy
cpl_idx  in  IDX_W  index being completed
flush  in  1  one-cycle flush request
flush_busy  out  1  high while in FLUSH
cpl_err  out  1  one-cycle pulse: accepted completion was illegal
count  out  IDX_W+1  occupied entries
sb_idx  out  IDX_W  scoreboard index
sb_pc_vld  out  1  scoreboard PC write
sb_pc  out  PC_WIDTH  scoreboard PC
sb_opcode_vld  out  1  scoreboard opcode write
sb_opcode  out  OPCODE_WIDTH  scoreboard opcode
sb_completed_vld  out  1  scoreboard completed set
sb_invalidate_vld  out  1  scoreboard invalidate

Behaviour:
- State: head, tail (IDX_W, wrap modulo SCRBRD_SIZE), count, occ[SIZE], done[SIZE], FSM {RUN, FLUSH}.
- Reset (rst=0, async): head=tail=0, count=0, occ=done=0, RUN.
- Reset values of outputs: all sb_* = 0, cpl_err=0, flush_busy=0.
- disp_rdy/cpl_rdy are 0 while rst is low.
- sb_* and cpl_err are registered: the command appears exactly 1 cycle after the accepting edge and lasts 1 cycle. sb_* are 0 in any cycle with no command.
- cpl_rdy = (RUN).
- disp_rdy = RUN && count<SCRBRD_SIZE && !cpl_vld. Completion has priority; dispatch is stalled that cycle.
- Per-cycle priority in RUN, exactly one action:
  1. completion
  2. dispatch
  3. retire
- Completion, legal (occ[cpl_idx]=1 and done=0): set done[cpl_idx]; next cycle sb_completed_vld=1, sb_idx=cpl_idx.
- Completion, illegal (otherwise): accepted, no state change, no sb command; cpl_err pulses next cycle.
- Dispatch: occ[tail]=1, done[tail]=0, tail+=1, count+=1; next cycle sb_pc_vld=sb_opcode_vld=1, sb_idx=old tail, sb_pc/sb_opcode = dispatched values.
- Retire: when no completion or dispatch is accepted, occ[head]=1 and done[head]=1: clear occ/done[head], head+=1, count-=1; next cycle sb_invalidate_vld=1, sb_idx=old head.
  - At most one retire per cycle.
  - Retire may starve under continuous traffic; the full condition eventually stalls dispatch.
- Full: count=SCRBRD_SIZE -> disp_rdy=0; completions and retire continue.
- Empty: no retire.
- Pointers wrap from SIZE-1 to 0.
- flush in RUN with count>0: flush takes precedence over that cycle's handshakes (disp_rdy and cpl_rdy are forced 0 that cycle); go to FLUSH.
- flush in RUN with count=0: no-op.
- FLUSH:
  - disp_rdy=cpl_rdy=0, flush_busy=1.
  - Each cycle, invalidate head (completed or not): sb_invalidate_vld next cycle, clear occ/done, head+=1, count-=1.
  - When count reaches 0, return to RUN; flush_busy drops the cycle after the last invalidate is issued.
  - flush while in FLUSH: ignored.
- Async reset mid-FLUSH or mid-command: everything returns to reset values immediately; no partial command is emitted.

Test Plan:
- SIZE=4. Dispatch PCs 0x100,0x104,0x108,0x10C back-to-back -> disp_idx 0,1,2,3; sb_pc_vld each following cycle with sb_idx 0..3; count=4; disp_rdy=0.
- Full (4). Complete idx 0 -> sb_completed_vld idx0; next idle cycle sb_invalidate_vld idx0; count=3; next dispatch gets idx0 (wrap).
- cpl_vld and disp_vld in same cycle -> completion accepted, disp_rdy=0; dispatch accepted the next cycle; sb commands are serialized on consecutive cycles.
- Complete idx 2 then idx 1 -> idx1 and idx2 retire in order idx1, idx2, only after idx0 has completed; completion of unoccupied idx 3 -> cpl_err pulse, no sb command.
- 3 entries occupied, flush -> flush_busy for 3 cycles; sb_invalidate_vld idx head, head+1, head+2; count=0; disp_rdy returns high.
- Drive rst low during FLUSH with count=2 -> outputs 0 immediately; after release, count=0, first dispatch gets idx0.

Source files
------------

// File: rtl/scrbrd_alloc.sv
// In-order scoreboard allocator: assigns circular indices to dispatched instructions,
// tracks completions, retires in program order and drives one scoreboard command per cycle.
module scrbrd_alloc #(
    parameter int SCRBRD_SIZE  = 32,
    parameter int PC_WIDTH     = 32,
    parameter int OPCODE_WIDTH = 7,
    localparam int IDX_W       = $clog2(SCRBRD_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    disp_vld,
    output logic                    disp_rdy,
    input  logic [PC_WIDTH-1:0]     disp_pc,
    input  logic [OPCODE_WIDTH-1:0] disp_opcode,
    output logic [IDX_W-1:0]        disp_idx,
    input  logic                    cpl_vld,
    output logic                    cpl_rdy,
    input  logic [IDX_W-1:0]        cpl_idx,
    input  logic                    flush,
    output logic                    flush_busy,
    output logic                    cpl_err,
    output logic [IDX_W:0]          count,
    output logic [IDX_W-1:0]        sb_idx,
    output logic                    sb_pc_vld,
    output logic [PC_WIDTH-1:0]     sb_pc,
    output logic                    sb_opcode_vld,
    output logic [OPCODE_WIDTH-1:0] sb_opcode,
    output logic                    sb_completed_vld,
    output logic                    sb_invalidate_vld
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(SCRBRD_SIZE);
    localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);

    state_t                 state;
    logic [IDX_W-1:0]       head;
    logic [IDX_W-1:0]       tail;
    logic [SCRBRD_SIZE-1:0] occ;
    logic [SCRBRD_SIZE-1:0] done;

    logic run;
    logic full;
    logic flush_take;
    logic cpl_acc;
    logic disp_acc;
    logic cpl_legal;
    logic retire;

    assign run        = (state == RUN);
    assign full       = (count == FULL_CNT);
    // A flush with live entries steals the cycle from both handshakes.
    assign flush_take = run && flush && (count != '0);
    assign cpl_rdy    = rst && run && !flush_take;
    assign disp_rdy   = rst && run && !flush_take && !full && !cpl_vld;
    assign disp_idx   = tail;
    assign cpl_acc    = cpl_vld && cpl_rdy;
    assign disp_acc   = disp_vld && disp_rdy;
    assign cpl_legal  = occ[cpl_idx] && !done[cpl_idx];
    assign retire     = run && !flush_take && !cpl_acc && !disp_acc && occ[head] && done[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= RUN;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            occ               <= '0;
            done              <= '0;
            flush_busy        <= 1'b0;
            cpl_err           <= 1'b0;
            sb_idx            <= '0;
            sb_pc_vld         <= 1'b0;
            sb_pc             <= '0;
            sb_opcode_vld     <= 1'b0;
            sb_opcode         <= '0;
            sb_completed_vld  <= 1'b0;
            sb_invalidate_vld <= 1'b0;
        end else begin
            cpl_err           <= 1'b0;
            sb_idx            <= '0;
            sb_pc_vld         <= 1'b0;
            sb_pc             <= '0;
            sb_opcode_vld     <= 1'b0;
            sb_opcode         <= '0;
            sb_completed_vld  <= 1'b0;
            sb_invalidate_vld <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_take) begin
                        state      <= FLUSH;
                        flush_busy <= 1'b1;
                    end else if (cpl_acc) begin
                        if (cpl_legal) begin
                            done[cpl_idx]    <= 1'b1;
                            sb_completed_vld <= 1'b1;
                            sb_idx           <= cpl_idx;
                        end else begin
                            cpl_err <= 1'b1;
                        end
                    end else if (disp_acc) begin
                        occ[tail]     <= 1'b1;
                        done[tail]    <= 1'b0;
                        tail          <= tail + 1'b1;
                        count         <= count + 1'b1;
                        sb_pc_vld     <= 1'b1;
                        sb_opcode_vld <= 1'b1;
                        sb_idx        <= tail;
                        sb_pc         <= disp_pc;
                        sb_opcode     <= disp_opcode;
                    end else if (retire) begin
                        occ[head]         <= 1'b0;
                        done[head]        <= 1'b0;
                        head              <= head + 1'b1;
                        count             <= count - 1'b1;
                        sb_invalidate_vld <= 1'b1;
                        sb_idx            <= head;
                    end
                end
                FLUSH: begin
                    // Entered only with count>0, so head is always live here.
                    occ[head]         <= 1'b0;
                    done[head]        <= 1'b0;
                    head              <= head + 1'b1;
                    count             <= count - 1'b1;
                    sb_invalidate_vld <= 1'b1;
                    sb_idx            <= head;
                    if (count == ONE_CNT) begin
                        state      <= RUN;
                        flush_busy <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_scrbrd_alloc.sv
// Self-checking bench for scrbrd_alloc: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_scrbrd_alloc;

    localparam int SIZE = 4;
    localparam int PCW  = 32;
    localparam int OPW  = 7;
    localparam int IW   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           disp_vld = 1'b0;
    logic           disp_rdy;
    logic [PCW-1:0] disp_pc = '0;
    logic [OPW-1:0] disp_opcode = '0;
    logic [IW-1:0]  disp_idx;
    logic           cpl_vld = 1'b0;
    logic           cpl_rdy;
    logic [IW-1:0]  cpl_idx = '0;
    logic           flush = 1'b0;
    logic           flush_busy;
    logic           cpl_err;
    logic [IW:0]    count;
    logic [IW-1:0]  sb_idx;
    logic           sb_pc_vld;
    logic [PCW-1:0] sb_pc;
    logic           sb_opcode_vld;
    logic [OPW-1:0] sb_opcode;
    logic           sb_completed_vld;
    logic           sb_invalidate_vld;

    scrbrd_alloc #(.SCRBRD_SIZE(SIZE), .PC_WIDTH(PCW), .OPCODE_WIDTH(OPW)) dut (
        .clk(clk), .rst(rst),
        .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_pc(disp_pc),
        .disp_opcode(disp_opcode), .disp_idx(disp_idx),
        .cpl_vld(cpl_vld), .cpl_rdy(cpl_rdy), .cpl_idx(cpl_idx),
        .flush(flush), .flush_busy(flush_busy), .cpl_err(cpl_err), .count(count),
        .sb_idx(sb_idx), .sb_pc_vld(sb_pc_vld), .sb_pc(sb_pc),
        .sb_opcode_vld(sb_opcode_vld), .sb_opcode(sb_opcode),
        .sb_completed_vld(sb_completed_vld), .sb_invalidate_vld(sb_invalidate_vld)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: program-ordered queue of live indices plus per-index done flags.
    int oq[$];
    bit mdone[SIZE];
    int mtail  = 0;
    bit mflush = 1'b0;

    // Expected registered command for the cycle after the edge.
    bit          e_pcv, e_opv, e_cv, e_iv, e_err;
    int          e_idx;
    logic [31:0] e_pc;
    logic [6:0]  e_op;

    // Combinational values sampled in the last step, for literal checks.
    bit last_disp_rdy;
    bit last_flush_busy;
    int last_disp_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input int idx);
        foreach (oq[k]) if (oq[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        oq.delete();
        foreach (mdone[k]) mdone[k] = 1'b0;
        mtail  = 0;
        mflush = 1'b0;
    endtask

    task automatic step(input bit dv, input logic [31:0] pc, input logic [6:0] op,
                        input bit cv, input int ci, input bit fl);
        bit er_c, er_d;
        int n, h;
        @(negedge clk);
        disp_vld = dv; disp_pc = pc; disp_opcode = op;
        cpl_vld = cv; cpl_idx = ci[IW-1:0]; flush = fl;
        #1;
        n    = oq.size();
        er_c = !mflush && !(fl && n > 0);
        er_d = er_c && (n < SIZE) && !cv;
        chk("cpl_rdy", cpl_rdy, er_c);
        chk("disp_rdy", disp_rdy, er_d);
        chk("count", count, n);
        chk("flush_busy", flush_busy, mflush);
        if (er_d) chk("disp_idx", disp_idx, mtail);
        last_disp_rdy   = disp_rdy;
        last_flush_busy = flush_busy;
        last_disp_idx   = int'(disp_idx);

        e_pcv = 0; e_opv = 0; e_cv = 0; e_iv = 0; e_err = 0;
        e_idx = 0; e_pc = '0; e_op = '0;
        if (mflush) begin
            h = oq.pop_front();
            mdone[h] = 1'b0;
            e_iv = 1; e_idx = h;
            if (oq.size() == 0) mflush = 1'b0;
        end else if (fl && n > 0) begin
            mflush = 1'b1;
        end else if (cv) begin
            if (in_q(ci) && !mdone[ci]) begin
                mdone[ci] = 1'b1;
                e_cv = 1; e_idx = ci;
            end else begin
                e_err = 1;
            end
        end else if (dv && n < SIZE) begin
            oq.push_back(mtail);
            mdone[mtail] = 1'b0;
            e_pcv = 1; e_opv = 1; e_idx = mtail; e_pc = pc; e_op = op;
            mtail = (mtail + 1) % SIZE;
        end else if (n > 0 && mdone[oq[0]]) begin
            h = oq.pop_front();
            mdone[h] = 1'b0;
            e_iv = 1; e_idx = h;
        end

        @(posedge clk);
        #1;
        chk("sb_pc_vld", sb_pc_vld, e_pcv);
        chk("sb_opcode_vld", sb_opcode_vld, e_opv);
        chk("sb_completed_vld", sb_completed_vld, e_cv);
        chk("sb_invalidate_vld", sb_invalidate_vld, e_iv);
        chk("cpl_err", cpl_err, e_err);
        chk("sb_idx", sb_idx, e_idx);
        chk("sb_pc", sb_pc, e_pc);
        chk("sb_opcode", sb_opcode, e_op);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        disp_vld = 1'b0; cpl_vld = 1'b0; flush = 1'b0;
        #1;
        chk("rst_sb_pc_vld", sb_pc_vld, 0);
        chk("rst_sb_opcode_vld", sb_opcode_vld, 0);
        chk("rst_sb_completed_vld", sb_completed_vld, 0);
        chk("rst_sb_invalidate_vld", sb_invalidate_vld, 0);
        chk("rst_sb_idx", sb_idx, 0);
        chk("rst_sb_pc", sb_pc, 0);
        chk("rst_sb_opcode", sb_opcode, 0);
        chk("rst_cpl_err", cpl_err, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_count", count, 0);
        chk("rst_disp_rdy", disp_rdy, 0);
        chk("rst_cpl_rdy", cpl_rdy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Fill all four entries.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(256 + 4 * i), 7'(i + 1), 1'b0, 0, 1'b0);
            chk("lit_disp_idx", last_disp_idx, i);
            chk("lit_fill_sb_idx", sb_idx, i);
            chk("lit_fill_pc_vld", sb_pc_vld, 1);
        end
        chk("lit_full_count", count, 4);
        chk("lit_full_rdy", disp_rdy, 0);
        chk("model_full_count", oq.size(), 4);

        // Complete idx0, retire it, then a simultaneous cpl+disp.
        step(1'b0, '0, '0, 1'b1, 0, 1'b0);
        chk("lit_cpl0", sb_completed_vld, 1);
        chk("lit_cpl0_idx", sb_idx, 0);
        idle();
        chk("lit_ret0", sb_invalidate_vld, 1);
        chk("lit_ret0_idx", sb_idx, 0);
        chk("lit_ret0_count", count, 3);
        step(1'b1, 32'h200, 7'd5, 1'b1, 2, 1'b0);
        chk("lit_cpl_prio_rdy", last_disp_rdy, 0);
        chk("lit_cpl2_idx", sb_idx, 2);
        step(1'b1, 32'h200, 7'd5, 1'b0, 0, 1'b0);
        chk("lit_wrap_idx", last_disp_idx, 0);
        chk("lit_wrap_sb_pc", sb_pc, 32'h200);

        // idx2 done but head idx1 is not: nothing retires until idx1 completes.
        idle();
        chk("lit_no_ret", sb_invalidate_vld, 0);
        step(1'b0, '0, '0, 1'b1, 1, 1'b0);
        chk("lit_cpl1_idx", sb_idx, 1);
        idle();
        chk("lit_ret1_idx", sb_idx, 1);
        idle();
        chk("lit_ret2_idx", sb_idx, 2);
        idle();
        chk("lit_ret3_none", sb_invalidate_vld, 0);
        step(1'b0, '0, '0, 1'b1, 1, 1'b0);
        chk("lit_err", cpl_err, 1);
        chk("lit_err_nocmd", sb_completed_vld, 0);

        // Queue is now 3,0; complete 3, double-complete 3, retire 3, add 1 and 2.
        step(1'b0, '0, '0, 1'b1, 3, 1'b0);
        step(1'b0, '0, '0, 1'b1, 3, 1'b0);
        chk("lit_double_err", cpl_err, 1);
        idle();
        chk("lit_ret3_idx", sb_idx, 3);
        step(1'b1, 32'h300, 7'd9, 1'b0, 0, 1'b0);
        step(1'b1, 32'h304, 7'd9, 1'b0, 0, 1'b0);
        chk("model_pre_flush", oq.size(), 3);

        // Flush three entries 0,1,2.
        step(1'b0, '0, '0, 1'b0, 0, 1'b1);
        chk("lit_flush_nocmd", sb_invalidate_vld, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h400, 7'd1, 1'b1, 0, 1'b1);
            chk("lit_flush_busy", last_flush_busy, 1);
            chk("lit_flush_inv", sb_invalidate_vld, 1);
            chk("lit_flush_idx", sb_idx, i);
        end
        idle();
        chk("lit_flush_done_busy", last_flush_busy, 0);
        chk("lit_flush_done_rdy", last_disp_rdy, 1);
        chk("lit_flush_done_count", count, 0);

        // Reset in the middle of a flush with two entries left.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500, 7'd2, 1'b0, 0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 0, 1'b1);
        idle();
        chk("lit_mid_flush_count", count, 2);
        do_reset();
        step(1'b1, 32'h600, 7'd3, 1'b0, 0, 1'b0);
        chk("lit_post_rst_idx", last_disp_idx, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            bit dv, cv, fl;
            int ci;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                dv = ($urandom_range(0, 9) < 6);
                cv = ($urandom_range(0, 9) < 3);
                fl = ($urandom_range(0, 39) == 0);
                if (oq.size() > 0 && $urandom_range(0, 9) < 7)
                    ci = oq[$urandom_range(0, oq.size() - 1)];
                else
                    ci = int'($urandom_range(0, SIZE - 1));
                step(dv, $urandom, 7'($urandom), cv, ci, fl);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
